// File: rtl/mult_div_ctrl.sv
// Sequencer for the iterative multiply/divide engine of the multicycle MIPS datapath.
// Walks LOAD -> CHECK -> INIT -> RUN x ITERATIONS -> WRITE -> DONE, with EXC on a zero divisor.
`timescale 1ns/1ps
module mult_div_ctrl #(
  parameter int unsigned ITERATIONS = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             divisor_zero,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             load_a,
  output logic             load_b,
  output logic             eng_init,
  output logic             eng_step,
  output logic             eng_op,
  output logic             hilo_write,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    EXC   = 3'd3,
    INIT  = 3'd4,
    RUN   = 3'd5,
    WRITE = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             eng_op_q, eng_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             load_q, load_d;
  logic             eng_init_q, eng_init_d;
  logic             eng_step_q, eng_step_d;
  logic             hilo_write_q, hilo_write_d;

  // Next state, iteration counter and op latch; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    step_count_d = '0;
    eng_op_d     = eng_op_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            eng_op_d = op;
            state_d  = LOAD;
          end
        end
        LOAD:  state_d = CHECK;
        CHECK: state_d = (eng_op_q && divisor_zero) ? EXC : INIT;
        EXC:   state_d = IDLE;
        INIT:  state_d = RUN;
        RUN: begin
          if (step_count_q == LAST_STEP) begin
            state_d      = WRITE;
            step_count_d = step_count_q;
          end else begin
            step_count_d = step_count_q + CNT_W'(1);
          end
        end
        WRITE: state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    busy_d        = (state_d != IDLE);
    load_d        = (state_d == LOAD);
    div_by_zero_d = (state_d == EXC);
    eng_init_d    = (state_d == INIT);
    eng_step_d    = (state_d == RUN);
    hilo_write_d  = (state_d == WRITE);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      step_count_q  <= '0;
      eng_op_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      load_q        <= 1'b0;
      eng_init_q    <= 1'b0;
      eng_step_q    <= 1'b0;
      hilo_write_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_count_q  <= step_count_d;
      eng_op_q      <= eng_op_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      load_q        <= load_d;
      eng_init_q    <= eng_init_d;
      eng_step_q    <= eng_step_d;
      hilo_write_q  <= hilo_write_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign load_a      = load_q;
  assign load_b      = load_q;
  assign eng_init    = eng_init_q;
  assign eng_step    = eng_step_q;
  assign eng_op      = eng_op_q;
  assign hilo_write  = hilo_write_q;
  assign step_count  = step_count_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: a per-cycle vector table on a 4-iteration instance plus
// timing-model sequences on the default 32-iteration instance.
`timescale 1ns/1ps
module tb_mult_div_ctrl;

  localparam logic [8:0] F_BUSY = 9'h100;
  localparam logic [8:0] F_DONE = 9'h080;
  localparam logic [8:0] F_DBZ  = 9'h040;
  localparam logic [8:0] F_LA   = 9'h020;
  localparam logic [8:0] F_LB   = 9'h010;
  localparam logic [8:0] F_INIT = 9'h008;
  localparam logic [8:0] F_STEP = 9'h004;
  localparam logic [8:0] F_OP   = 9'h002;
  localparam logic [8:0] F_HILO = 9'h001;

  logic clk, reset;
  logic start, op, dz, abort;
  logic s_start, s_op, s_dz, s_abort;

  logic b_busy, b_done, b_dbz, b_la, b_lb, b_init, b_step, b_op, b_hilo;
  logic [5:0] b_cnt;
  logic s_busy, s_done, s_dbz, s_la, s_lb, s_init, s_step, s_eop, s_hilo;
  logic [1:0] s_cnt;
  logic [8:0] b_flags, s_flags;

  int total = 0;
  int bad   = 0;

  assign b_flags = {b_busy, b_done, b_dbz, b_la, b_lb, b_init, b_step, b_op, b_hilo};
  assign s_flags = {s_busy, s_done, s_dbz, s_la, s_lb, s_init, s_step, s_eop, s_hilo};

  mult_div_ctrl u_big (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(dz), .abort(abort),
    .busy(b_busy), .done(b_done), .div_by_zero(b_dbz), .load_a(b_la), .load_b(b_lb),
    .eng_init(b_init), .eng_step(b_step), .eng_op(b_op), .hilo_write(b_hilo),
    .step_count(b_cnt)
  );

  mult_div_ctrl #(.ITERATIONS(4), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .divisor_zero(s_dz), .abort(s_abort),
    .busy(s_busy), .done(s_done), .div_by_zero(s_dbz), .load_a(s_la), .load_b(s_lb),
    .eng_init(s_init), .eng_step(s_step), .eng_op(s_eop), .hilo_write(s_hilo),
    .step_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       op;
    logic       dz;
    logic       abort;
    logic [8:0] f;
    int         c;
  } vec_t;

  typedef struct {
    logic [8:0] f;
    int         c;
  } exp_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [8:0] af, input int ac,
                       input logic [8:0] ef, input int ec);
    total++;
    if (af !== ef || ac != ec) begin
      bad++;
      $display("FAIL %s: flags=%b cnt=%0d expected flags=%b cnt=%0d", name, af, ac, ef, ec);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Expected outputs n cycles after the edge that accepted start.
  function automatic exp_t model(input int n, input bit o, input bit d, input int iters);
    exp_t e;
    bit exc;
    exc = o && d;
    e.f = o ? F_OP : 9'h000;
    e.c = 0;
    if (n == 1)                               e.f |= F_BUSY | F_LA | F_LB;
    else if (n == 2)                          e.f |= F_BUSY;
    else if (n == 3)                          e.f |= F_BUSY | (exc ? F_DBZ : F_INIT);
    else if (!exc && n >= 4 && n <= 3 + iters) begin
      e.f |= F_BUSY | F_STEP;
      e.c = n - 4;
    end else if (!exc && n == 4 + iters) begin
      e.f |= F_BUSY | F_HILO;
      e.c = iters - 1;
    end else if (!exc && n == 5 + iters)      e.f |= F_BUSY | F_DONE;
    return e;
  endfunction

  // Issues one start on the 32-iteration instance and checks ncyc following cycles.
  task automatic run_op(input string tag, input bit o, input bit d, input int ncyc,
                        input int abort_at, input int ex1, input int ex2,
                        input int exp_step, input int exp_hilo, input int exp_done,
                        input int exp_dbz);
    exp_t e;
    int n_step, n_hilo, n_done, n_dbz;
    n_step = 0; n_hilo = 0; n_done = 0; n_dbz = 0;
    start = 1'b1; op = o; dz = d; abort = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (abort_at >= 0 && n > abort_at) begin
        e.f = o ? F_OP : 9'h000;
        e.c = 0;
      end else begin
        e = model(n, o, d, 32);
      end
      check($sformatf("%s@k+%0d", tag, n), b_flags, int'(b_cnt), e.f, e.c);
      n_step += int'(b_step);
      n_hilo += int'(b_hilo);
      n_done += int'(b_done);
      n_dbz  += int'(b_dbz);
      start = (n == ex1) || (n == ex2);
      op    = start ? ~o : o;
      abort = (n == abort_at);
    end
    start = 1'b0; abort = 1'b0; op = o;
    check_int({tag, "_steps"}, n_step, exp_step);
    check_int({tag, "_hilo"},  n_hilo, exp_hilo);
    check_int({tag, "_done"},  n_done, exp_done);
    check_int({tag, "_dbz"},   n_dbz,  exp_dbz);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, F_BUSY | F_LA | F_LB, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_INIT, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_STEP, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_STEP, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_STEP, 2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_STEP, 3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_HILO, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_BUSY | F_DONE, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, F_BUSY | F_LA | F_LB | F_OP, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, F_BUSY | F_OP, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, F_BUSY | F_DBZ | F_OP, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, F_OP, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, F_OP, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, F_BUSY | F_LA | F_LB, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 0};

    reset = 1'b0;
    start = 1'b0; op = 1'b0; dz = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_op = 1'b0; s_dz = 1'b0; s_abort = 1'b0;
    #2;
    check("reset_big", b_flags, int'(b_cnt), 9'h000, 0);
    check("reset_small", s_flags, int'(s_cnt), 9'h000, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      s_start = tbl[i].start;
      s_op    = tbl[i].op;
      s_dz    = tbl[i].dz;
      s_abort = tbl[i].abort;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), s_flags, int'(s_cnt), tbl[i].f, tbl[i].c);
    end
    s_start = 1'b0; s_op = 1'b0; s_dz = 1'b0; s_abort = 1'b0;

    run_op("mult",        1'b0, 1'b0, 40, -1, -1, -1, 32, 1, 1, 0);
    run_op("div_zero",    1'b1, 1'b1,  8, -1, -1, -1,  0, 0, 0, 1);
    run_op("div",         1'b1, 1'b0, 40, -1, 10, 37, 32, 1, 1, 0);
    run_op("abort",       1'b0, 1'b0, 15, 14, -1, -1, 11, 0, 0, 0);
    run_op("after_abort", 1'b1, 1'b0, 40, -1, -1, -1, 32, 1, 1, 0);
    run_op("pre_reset",   1'b1, 1'b0, 20, -1, -1, -1, 17, 0, 0, 0);

    // Asynchronous reset between clock edges, mid-RUN.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_big", b_flags, int'(b_cnt), 9'h000, 0);
    check("async_reset_small", s_flags, int'(s_cnt), 9'h000, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("post_reset",  1'b0, 1'b0, 40, -1, -1, -1, 32, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
